ctrl_cdc_arbiter: RTL and testbench

- Shares the single 4-bit control crossing between `NUM_REQ` requesters in the `clkA` domain.
- Picks one requester round-robin and drives its word onto the crossing input.
- Holds that word stable long enough for the two-flop `clkB` synchronizer to capture it, then returns the bus to an idle code before the next word.
- Sits directly upstream of the crossing's `ctrl_in`.

---
 rtl/ctrl_cdc_pkg.sv | 13 +
 rtl/ctrl_cdc_arbiter_rr_pick.sv | 33 +++
 rtl/ctrl_cdc_arbiter.sv | 107 ++++++++++
 tb/tb_ctrl_cdc_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_cdc_pkg.sv
// Shared types and constants for the 4-bit control crossing and its arbiter.
package ctrl_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned       CTRL_WIDTH     = 4;
  localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE_CODE = 4'b0000;

endpackage

// File: rtl/ctrl_cdc_arbiter_rr_pick.sv
// Combinational round-robin selector: search starts one past the pointer and
// wraps, returning a one-hot winner, its index and a valid flag.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned       cand;
    logic [PTR_W-1:0]  cand_idx;
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand     = (32'(ptr_i) + off) % N;
      cand_idx = PTR_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ctrl_cdc_arbiter.sv
// Round-robin arbiter sharing one control crossing: each granted word is held
// for HOLD_CYCLES, then IDLE_CODE for GAP_CYCLES before the next arbitration.
module ctrl_cdc_arbiter
  import ctrl_cdc_pkg::*;
#(
  parameter int unsigned           NUM_REQ     = 4,
  parameter int unsigned           WIDTH       = CTRL_WIDTH,
  parameter int unsigned           HOLD_CYCLES = 4,
  parameter int unsigned           GAP_CYCLES  = 2,
  parameter logic [WIDTH-1:0]      IDLE_CODE   = CTRL_IDLE_CODE
) (
  input  logic                     clkA,
  input  logic                     rstA,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [WIDTH-1:0]         ctrl_out
);

  localparam int unsigned PTR_W    = $clog2(NUM_REQ);
  localparam logic [7:0]  HOLD_END = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0]  GAP_END  = 8'(GAP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [WIDTH-1:0]   ctrl_q, ctrl_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [WIDTH-1:0]   pick_word;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_word = pick_word | req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    ctrl_d  = ctrl_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          ctrl_d  = pick_word;
          ptr_d   = pick_idx;
          cnt_d   = HOLD_END;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          ctrl_d  = IDLE_CODE;
          cnt_d   = GAP_END;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkA) begin
    if (!rstA) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      ctrl_q  <= IDLE_CODE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign grant    = grant_q;
  assign ctrl_out = ctrl_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ctrl_cdc_arbiter.sv
// Directed bench for ctrl_cdc_arbiter: default timing instance plus a short
// HOLD=3/GAP=1 instance; expected values are computed from the timing rules.
module tb_ctrl_cdc_arbiter;

  logic        clkA = 1'b0;
  logic        rstA;
  logic [3:0]  req, req2;
  logic [15:0] req_data, req_data2;
  logic [3:0]  grant, grant2;
  logic        busy, busy2;
  logic [3:0]  ctrl_out, ctrl_out2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clkA = ~clkA;

  ctrl_cdc_arbiter #(
    .NUM_REQ     (4),
    .WIDTH       (4),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .IDLE_CODE   (4'b0000)
  ) u_dut (
    .clkA     (clkA),
    .rstA     (rstA),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .busy     (busy),
    .ctrl_out (ctrl_out)
  );

  ctrl_cdc_arbiter #(
    .NUM_REQ     (4),
    .WIDTH       (4),
    .HOLD_CYCLES (3),
    .GAP_CYCLES  (1),
    .IDLE_CODE   (4'b0000)
  ) u_dut_short (
    .clkA     (clkA),
    .rstA     (rstA),
    .req      (req2),
    .req_data (req_data2),
    .grant    (grant2),
    .busy     (busy2),
    .ctrl_out (ctrl_out2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkA);
    #1;
  endtask

  task automatic do_reset();
    rstA = 1'b0;
    step();
    rstA = 1'b1;
  endtask

  initial begin
    int unsigned ph, w;
    logic [3:0] exp_g;
    logic [3:0] exp_c;

    rstA      = 1'b0;
    req       = '0;
    req2      = '0;
    req_data  = '0;
    req_data2 = '0;
    step();
    step();
    chk("rst_ctrl",  32'(ctrl_out), 32'h0);
    chk("rst_grant", 32'(grant),    32'h0);
    chk("rst_busy",  32'(busy),     32'h0);
    rstA = 1'b1;

    // Single request: grant pulse, 4 cycles of A, 2 of idle, then IDLE.
    req      = 4'b0001;
    req_data = 16'h000A;
    for (int unsigned k = 1; k <= 7; k++) begin
      step();
      req = '0;
      chk("t1_grant", 32'(grant),    (k == 1) ? 32'h1 : 32'h0);
      chk("t1_ctrl",  32'(ctrl_out), (k <= 4) ? 32'hA : 32'h0);
      chk("t1_busy",  32'(busy),     (k <= 6) ? 32'h1 : 32'h0);
    end

    // All four requesters held high: 0,1,2,3,0 every 7 cycles.
    do_reset();
    req      = 4'b1111;
    req_data = 16'h4321;
    for (int unsigned k = 1; k <= 29; k++) begin
      step();
      ph    = (k - 1) % 7;
      w     = ((k - 1) / 7) % 4;
      exp_g = (ph == 0) ? 4'(1 << w) : 4'h0;
      exp_c = (ph < 4) ? 4'(w + 1) : 4'h0;
      chk("t2_grant", 32'(grant),    32'(exp_g));
      chk("t2_ctrl",  32'(ctrl_out), 32'(exp_c));
      chk("t2_busy",  32'(busy),     (ph < 6) ? 32'h1 : 32'h0);
    end
    req = '0;

    // Request for 2 arrives mid-HOLD: ignored until IDLE.
    do_reset();
    req      = 4'b0001;
    req_data = 16'h050A;
    for (int unsigned k = 1; k <= 14; k++) begin
      step();
      if (k == 1) req = '0;
      if (k == 2) req = 4'b0100;
      if (k == 8) req = '0;
      exp_g = (k == 1) ? 4'b0001 : (k == 8) ? 4'b0100 : 4'b0000;
      exp_c = (k <= 4) ? 4'hA : (k >= 8 && k <= 11) ? 4'h5 : 4'h0;
      chk("t3_grant", 32'(grant),    32'(exp_g));
      chk("t3_ctrl",  32'(ctrl_out), 32'(exp_c));
    end

    // Reset during HOLD abandons the word; requester 0 wins afterwards.
    do_reset();
    req      = 4'b0001;
    req_data = 16'h4321;
    step();
    req = '0;
    step();
    step();
    chk("t4_pre_ctrl", 32'(ctrl_out), 32'h1);
    rstA = 1'b0;
    step();
    chk("t4_rst_ctrl",  32'(ctrl_out), 32'h0);
    chk("t4_rst_busy",  32'(busy),     32'h0);
    chk("t4_rst_grant", 32'(grant),    32'h0);
    rstA = 1'b1;
    req  = 4'b1111;
    step();
    req = '0;
    chk("t4_grant", 32'(grant),    32'h1);
    chk("t4_ctrl",  32'(ctrl_out), 32'h1);
    for (int unsigned k = 0; k < 7; k++) step();
    chk("t4_idle_busy", 32'(busy), 32'h0);

    // Short instance: 3-cycle hold, 1-cycle gap, grants 5 apart, idle-code data.
    do_reset();
    req2      = 4'b0011;
    req_data2 = 16'h0090;
    for (int unsigned k = 1; k <= 15; k++) begin
      step();
      ph    = (k - 1) % 5;
      w     = ((k - 1) / 5) % 2;
      exp_g = (ph == 0) ? 4'(1 << w) : 4'h0;
      exp_c = (ph < 3 && w == 1) ? 4'h9 : 4'h0;
      chk("t5_grant", 32'(grant2),    32'(exp_g));
      chk("t5_ctrl",  32'(ctrl_out2), 32'(exp_c));
      chk("t5_busy",  32'(busy2),     (ph < 4) ? 32'h1 : 32'h0);
    end
    req2 = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
